// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared constants, FSM state type and code helper for the mouse key sequencer
package mouse_pkg;

  localparam int KEY_W    = 5;
  localparam int NUM_KEYS = 18;
  localparam int CNT_W    = 8;
  localparam logic [KEY_W-1:0] NONE_CODE = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PUSH    = 2'd2,
    ST_RELEASE = 2'd3
  } seq_state_e;

  // Codes above "no key" come from decoder states with no keypad meaning; fold them into no key.
  function automatic logic [KEY_W-1:0] squash_code(input logic [KEY_W-1:0] code,
                                                   input logic [KEY_W-1:0] none_code);
    return (code >= none_code) ? none_code : code;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - small first-word-fall-through FIFO for debounced key events
module key_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts a write when read.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mouse_key_sequencer.sv
// rtl/mouse_key_sequencer.sv - debounces raw mouse key codes into one queued event per click
module mouse_key_sequencer
  import mouse_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter logic [KEY_W-1:0] NONE_CODE = mouse_pkg::NONE_CODE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [KEY_W-1:0]              key_code,
  input  logic                          key_ready,
  input  logic                          clear_ovf,
  output logic [KEY_W-1:0]              key_out,
  output logic                          key_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             ovf_q, ovf_d;

  logic [KEY_W-1:0] code_eff;
  logic [KEY_W-1:0] fifo_head;
  logic             fifo_empty, fifo_full;
  logic             push_en, ovf_set, pop;

  assign code_eff  = squash_code(code_q, NONE_CODE);
  assign key_valid = !fifo_empty;
  assign key_out   = fifo_empty ? '0 : fifo_head;
  assign pop       = key_valid && key_ready;
  assign overflow  = ovf_q;
  assign busy      = (state_q != ST_IDLE);

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_en),
    .wr_data (cand_q),
    .rd_en   (key_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Press/release debounce: a key must be stable to fire once, then no key must be stable to re-arm.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = key_code;
    push_en = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_eff != NONE_CODE) begin
          state_d = ST_HOLD;
          cand_d  = code_eff;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (code_eff == NONE_CODE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (code_eff != cand_q) begin
          cand_d = code_eff;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q >= HOLD_LIM) begin
          state_d = ST_PUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PUSH: begin
        if (!fifo_full || pop) begin
          push_en = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
      ST_RELEASE: begin
        // Any held key, including a slide onto a neighbour, restarts the release count.
        if (code_eff == NONE_CODE) begin
          if ({1'b0, cnt_q} + 9'd1 >= {1'b0, HOLD_LIM}) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ovf_d = ovf_set ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
  end

  // Sequencer state, input sample and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= NONE_CODE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mouse_key_sequencer.sv
// tb/tb_mouse_key_sequencer.sv - self-checking bench for mouse_key_sequencer
module tb_mouse_key_sequencer;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;
  localparam int NONE  = 18;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_code = 5'd18;
  logic       key_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [4:0] key_out;
  logic       key_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mouse_key_sequencer #(
    .HOLD_CYCLES (HOLD),
    .FIFO_DEPTH  (DEPTH),
    .NONE_CODE   (5'd18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .clear_ovf  (clear_ovf),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: a click fires once the FSM has seen HOLD+1 identical key samples while armed;
  // after firing it is disarmed until HOLD consecutive no-key samples have been seen.
  int  mq[$];
  bit  m_armed;
  int  m_run_code;
  int  m_run_len;
  int  m_none_len;
  bit  m_pending;
  bit  m_ovf;
  int  m_last;

  function automatic int eff(input int k);
    return (k >= NONE) ? NONE : k;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_armed    = 1'b1;
    m_run_code = NONE;
    m_run_len  = 0;
    m_none_len = 0;
    m_pending  = 1'b0;
    m_ovf      = 1'b0;
    m_last     = NONE;
  endtask

  task automatic model_step(input int k, input bit r, input bit c);
    bit pop;
    bit push_now;
    bit ovf_set;
    pop      = (mq.size() > 0) && r;
    push_now = m_pending;
    ovf_set  = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push_now) begin
      if (mq.size() < DEPTH) mq.push_back(m_run_code);
      else ovf_set = 1'b1;
    end
    m_ovf     = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_pending = 1'b0;
    if (!push_now) begin
      if (m_armed) begin
        if (m_last == NONE) m_run_len = 0;
        else if (m_run_len > 0 && m_last == m_run_code) m_run_len++;
        else begin
          m_run_code = m_last;
          m_run_len  = 1;
        end
        if (m_run_len == HOLD + 1) begin
          m_pending  = 1'b1;
          m_armed    = 1'b0;
          m_none_len = 0;
          m_run_len  = 0;
        end
      end else begin
        if (m_last == NONE) begin
          m_none_len++;
          if (m_none_len == HOLD) m_armed = 1'b1;
        end else begin
          m_none_len = 0;
        end
      end
    end
    m_last = eff(k);
  endtask

  task automatic check_model();
    bit ev;
    int ek, en, eb;
    ev = (mq.size() > 0);
    ek = ev ? mq[0] : 0;
    en = mq.size();
    eb = !(m_armed && m_run_len == 0 && !m_pending);
    checks++;
    if (key_valid !== ev || int'(key_out) != ek || int'(fifo_count) != en ||
        overflow !== m_ovf || int'(busy) != eb) begin
      errors++;
      $display("FAIL model_cmp cycle %0d: got valid=%0b key=%0d count=%0d ovf=%0b busy=%0b, expected valid=%0b key=%0d count=%0d ovf=%0b busy=%0d",
               cyc, key_valid, key_out, fifo_count, overflow, busy, ev, ek, en, m_ovf, eb);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic cycle(input int k, input bit r, input bit c);
    @(negedge clk);
    key_code  = 5'(k);
    key_ready = r;
    clear_ovf = c;
    @(posedge clk);
    #1;
    cyc++;
    model_step(k, r, c);
    check_model();
  endtask

  // Hold k long enough to fire, present r/c on the push edge, then release long enough to re-arm.
  task automatic click(input int k, input bit r_push, input bit c_push);
    for (int i = 0; i < 6; i++) cycle(k, 1'b0, 1'b0);
    cycle(NONE, r_push, c_push);
    for (int i = 0; i < 7; i++) cycle(NONE, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "_valid"}, int'(key_valid), 0);
    check_val({name, "_key"},   int'(key_out),   0);
    check_val({name, "_count"}, int'(fifo_count), 0);
    check_val({name, "_ovf"},   int'(overflow),  0);
    check_val({name, "_busy"},  int'(busy),      0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(name);
    model_reset();
    @(negedge clk);
    key_code  = 5'd18;
    key_ready = 1'b0;
    clear_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int n;
    int k;
    bit r;
    bit c;
    bit ev;
    int ek;
    int en;
    bit eo;
    bit eb;
  } vec_t;

  vec_t vt[12];
  int   exp_order[4];

  initial begin
    vt[0]  = '{1, 7,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vt[1]  = '{5, 7,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
    vt[2]  = '{4, 7,  1'b0, 1'b0, 1'b1, 7, 1, 1'b0, 1'b1};
    vt[3]  = '{4, 18, 1'b0, 1'b0, 1'b1, 7, 1, 1'b0, 1'b1};
    vt[4]  = '{6, 18, 1'b0, 1'b0, 1'b1, 7, 1, 1'b0, 1'b0};
    vt[5]  = '{1, 18, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vt[6]  = '{1, 3,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vt[7]  = '{1, 3,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
    vt[8]  = '{1, 18, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
    vt[9]  = '{4, 18, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vt[10] = '{3, 25, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vt[11] = '{2, 31, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};

    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single click, glitch and out-of-range codes from the table.
    for (int v = 0; v < 12; v++) begin
      for (int j = 0; j < vt[v].n; j++) begin
        cycle(vt[v].k, vt[v].r, vt[v].c);
        checks++;
        if (key_valid !== vt[v].ev || int'(key_out) != vt[v].ek || int'(fifo_count) != vt[v].en ||
            overflow !== vt[v].eo || busy !== vt[v].eb) begin
          errors++;
          $display("FAIL vec%0d.%0d: got valid=%0b key=%0d count=%0d ovf=%0b busy=%0b, expected valid=%0b key=%0d count=%0d ovf=%0b busy=%0b",
                   v, j, key_valid, key_out, fifo_count, overflow, busy,
                   vt[v].ev, vt[v].ek, vt[v].en, vt[v].eo, vt[v].eb);
        end
      end
    end

    // Slide 5 -> 11 before the hold completes, then slide to 2 while held.
    for (int i = 0; i < 3; i++) cycle(5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(2, 1'b0, 1'b0);
    check_val("slide_count", int'(fifo_count), 1);
    check_val("slide_key", int'(key_out), 11);
    check_val("slide_busy_held", int'(busy), 1);
    for (int i = 0; i < 4; i++) cycle(NONE, 1'b0, 1'b0);
    check_val("slide_busy_release", int'(busy), 1);
    cycle(NONE, 1'b0, 1'b0);
    check_val("slide_idle", int'(busy), 0);
    cycle(NONE, 1'b1, 1'b0);
    check_val("slide_popped", int'(fifo_count), 0);

    // Five clicks into a four-entry FIFO with no consumer.
    for (int k = 0; k < 5; k++) click(k, 1'b0, 1'b0);
    check_val("ovf_count", int'(fifo_count), 4);
    check_val("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      check_val("pop_order", int'(key_out), i);
      cycle(NONE, 1'b1, 1'b0);
    end
    check_val("drained", int'(fifo_count), 0);
    cycle(NONE, 1'b0, 1'b1);
    check_val("ovf_cleared", int'(overflow), 0);

    // Full FIFO: set beats clear, then a pop on the push edge makes room.
    for (int k = 12; k < 16; k++) click(k, 1'b0, 1'b0);
    click(8, 1'b0, 1'b1);
    check_val("set_wins", int'(overflow), 1);
    cycle(NONE, 1'b0, 1'b1);
    check_val("ovf_cleared2", int'(overflow), 0);
    click(9, 1'b1, 1'b0);
    check_val("pushpop_count", int'(fifo_count), 4);
    check_val("pushpop_ovf", int'(overflow), 0);
    exp_order = '{13, 14, 15, 9};
    for (int i = 0; i < 4; i++) begin
      check_val("pushpop_order", int'(key_out), exp_order[i]);
      cycle(NONE, 1'b1, 1'b0);
    end

    // Reset in the middle of a hold on key 6.
    for (int i = 0; i < 3; i++) cycle(6, 1'b0, 1'b0);
    check_val("hold_busy", int'(busy), 1);
    do_reset("rst_hold");
    for (int i = 0; i < 5; i++) cycle(NONE, 1'b0, 1'b0);
    check_val("rst_hold_idle", int'(busy), 0);

    // Reset with two queued events.
    click(1, 1'b0, 1'b0);
    click(2, 1'b0, 1'b0);
    check_val("queued_two", int'(fifo_count), 2);
    do_reset("rst_queued");
    for (int i = 0; i < 3; i++) cycle(NONE, 1'b0, 1'b0);
    check_val("rst_queued_idle", int'(busy), 0);

    // Random runs of codes with a sporadic consumer and clear pulses.
    for (int c = 0; c < 1500;) begin
      int sel, k, len;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      k = int'($urandom_range(0, 17));
      else if (sel < 9) k = NONE;
      else              k = int'($urandom_range(19, 31));
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) begin
        cycle(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        c++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_key_sequencer.md
Name: mouse_key_sequencer

Overview:
- Sequences raw key codes from the mouse-to-keypad decoder into clean, debounced, one-per-click key events for the calculator microcontroller.
- Input is the 5-bit key code:
  - 0..17 = key under the cursor with the button held.
  - 18 = no key.
- Debounces the press, emits exactly one event per click, then requires a debounced release before re-arming.
- Events are buffered in a small first-word-fall-through FIFO, read by the CPU side through a valid/ready handshake.

Parameters:
- HOLD_CYCLES, 16: consecutive cycles a code must be stable to count as a press (and NONE as a release). Legal range 1..255.
- FIFO_DEPTH, 4: key event FIFO entries. Must be a power of 2, at least 2.
- NONE_CODE, 18: code meaning "no key".

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_code  in  5  raw key code from the decoder; combinational, asynchronous to click timing.
- key_ready  in  1  consumer accepts the head entry this cycle.
- clear_ovf  in  1  clears the sticky overflow flag.
- key_out  out  5  FIFO head key code; 0 when empty.
- key_valid  out  1  FIFO not empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of entries held.
- overflow  out  1  sticky: a press was dropped because the FIFO was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, active-high):
  - State IDLE; counter 0; candidate 0; code_q = NONE_CODE.
  - FIFO empty; key_out 0; key_valid 0; fifo_count 0; overflow 0; busy 0.
- Input stage:
  - code_q registers key_code every cycle.
  - Any code_q > NONE_CODE (19..31) is treated as NONE_CODE.
- FSM states: IDLE, HOLD, PUSH, RELEASE.
  - IDLE:
    - code_q != NONE → HOLD, candidate = code_q, cnt = 1.
  - HOLD:
    - code_q == candidate and cnt < HOLD_CYCLES → cnt++.
    - code_q == candidate and cnt == HOLD_CYCLES → PUSH.
    - code_q == NONE → IDLE; no event.
    - code_q is a different valid key → stay in HOLD, candidate = code_q, cnt = 1.
  - PUSH (exactly one cycle):
    - FIFO not full → write candidate.
    - FIFO full → drop candidate, set overflow.
    - Then → RELEASE, cnt = 0.
  - RELEASE:
    - code_q == NONE → cnt++; at cnt == HOLD_CYCLES → IDLE.
    - Any non-NONE code → cnt = 0. Sliding onto another key while held never produces a second event.
- Latency:
  - key_code = K held from clock edge e0, FIFO empty → key_valid = 1 and key_out = K after edge e0 + HOLD_CYCLES + 2.
  - A press shorter than HOLD_CYCLES samples produces no event.
- Counter width is 8 bits and must never wrap within the legal HOLD_CYCLES range.
- FIFO (FWFT):
  - key_out and key_valid reflect the head combinationally from registered storage.
  - A pop happens on key_valid && key_ready.
  - Push and pop in the same cycle: both take effect, count unchanged. This is legal when full: pop frees the slot, push succeeds, overflow not set.
  - key_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - Sticky until clear_ovf.
  - Set and clear in the same cycle → set wins.
- Reset asserted mid-HOLD or mid-PUSH discards the pending candidate; the FIFO contents are lost.

Decomposition:
- Shared package mouse_pkg:
  - NONE_CODE = 18, NUM_KEYS = 18, KEY_W = 5.
  - FSM state encoding: IDLE=0, HOLD=1, PUSH=2, RELEASE=3.
- One sub-module, key_fifo: synchronous FWFT FIFO, parameterised on width and depth.
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, empty, full, count.
- The FSM and counter live in mouse_key_sequencer.

Test Plan:
- HOLD_CYCLES=4: key_code=7 for 10 cycles, then 18 for 10 cycles → exactly one event; key_valid rises 6 cycles after code onset; key_out=7; busy returns to 0.
- key_code=3 for 2 cycles then 18 (glitch) → no event; fifo_count stays 0; FSM back in IDLE.
- key_code=5 held, slid to 11 before HOLD completes, 11 held → one event with code 11. Then slid to 2 while still held → no further event until 18 has been held for HOLD_CYCLES cycles.
- Five clicks (0,1,2,3,4) with key_ready=0, FIFO_DEPTH=4 → fifo_count=4, overflow=1. Pop four times → order 0,1,2,3. Pulse clear_ovf → overflow=0.
- FIFO full, with key_ready=1 in the exact PUSH cycle of a new click (code 9) → count stays 4, overflow stays 0, 9 becomes the last entry.
- Reset asserted while in HOLD with candidate 6, and again with 2 entries queued → all outputs 0 after reset. Releasing reset with key_code=18 stays IDLE.
